// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package fetch_pkg;

  localparam int          FETCH_DEPTH_DEFAULT = 4;
  localparam logic [31:0] INSTR_NOP           = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_buffer_slots.sv
// Slot storage for the fetch buffer: PC written at alloc, instruction at fill,
// head slot read combinationally. Only the filled bits are reset.
module FetchSlots
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH_DEFAULT,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          alloc_we_i,
  input  logic [PW-1:0] alloc_idx_i,
  input  logic [31:0]   alloc_pc_i,
  input  logic          fill_we_i,
  input  logic [PW-1:0] fill_idx_i,
  input  logic [31:0]   fill_data_i,
  input  logic          pop_i,
  input  logic [PW-1:0] rd_idx_i,
  output logic [31:0]   head_pc_o,
  output logic [31:0]   head_instr_o,
  output logic          head_filled_o
);

  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  fetch_slot_t      head;

  always_ff @(posedge clk) begin
    if (alloc_we_i) pc_q[alloc_idx_i]   <= alloc_pc_i;
    if (fill_we_i)  instr_q[fill_idx_i] <= fill_data_i;
  end

  // Alloc, fill and pop never target the same slot in one cycle, so order is free.
  always_comb begin
    filled_d = filled_q;
    if (flush_i) begin
      filled_d = '0;
    end else begin
      if (pop_i)      filled_d[rd_idx_i]    = 1'b0;
      if (alloc_we_i) filled_d[alloc_idx_i] = 1'b0;
      if (fill_we_i)  filled_d[fill_idx_i]  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) filled_q <= '0;
    else      filled_q <= filled_d;
  end

  assign head          = '{pc: pc_q[rd_idx_i], instr: instr_q[rd_idx_i], filled: filled_q[rd_idx_i]};
  assign head_pc_o     = head.pc;
  assign head_instr_o  = head.instr;
  assign head_filled_o = head.filled;

endmodule

// File: rtl/fetch_buffer.sv
// In-order fetch buffer: issues imem reads, reserves a slot per request and
// hands {pc, instr} to decode; flush discards queued work and owed responses.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_valid,
  input  logic [31:0] pc_in,
  output logic        pc_ready,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        flush,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PONE    = PW'(1);

  logic [PW-1:0] alloc_q, alloc_d, fill_q, fill_d, rd_q, rd_d;
  logic [PW:0]   count_q, count_d, pend_q, pend_d, drop_q, drop_d;
  logic [PW:0]   fire_w, keep_w, pop_w, rsp_w, kept_now;
  logic          can_req, fire, keep, pop, draining;
  logic          head_filled;
  logic [31:0]   head_pc, head_instr;

  assign draining = (drop_q != '0);
  // Gating with rst keeps the request side quiet while reset is held.
  assign can_req        = rst && (count_q < DEPTH_C) && !draining && !flush;
  assign pc_ready       = can_req && imem_req_ready;
  assign imem_req_valid = can_req && pc_valid;
  assign imem_req_addr  = pc_in;

  assign fire        = pc_valid && pc_ready;
  assign keep        = imem_rsp_valid && !draining && !flush;
  assign instr_valid = head_filled && !flush;
  assign pop         = instr_valid && instr_ready;
  assign instr       = instr_valid ? head_instr : INSTR_NOP;
  assign instr_pc    = head_pc;

  assign fire_w   = {{PW{1'b0}}, fire};
  assign keep_w   = {{PW{1'b0}}, keep};
  assign pop_w    = {{PW{1'b0}}, pop};
  assign rsp_w    = {{PW{1'b0}}, imem_rsp_valid};
  assign kept_now = {{PW{1'b0}}, imem_rsp_valid && !draining};

  always_comb begin
    alloc_d = alloc_q;
    fill_d  = fill_q;
    rd_d    = rd_q;
    count_d = count_q;
    pend_d  = pend_q;
    drop_d  = drop_q;
    if (flush) begin
      alloc_d = '0;
      fill_d  = '0;
      rd_d    = '0;
      count_d = '0;
      pend_d  = '0;
      // Every response still owed after this cycle must be swallowed.
      drop_d  = pend_q - kept_now + (draining ? drop_q - rsp_w : '0);
    end else begin
      if (fire) alloc_d = alloc_q + PONE;
      if (keep) fill_d  = fill_q + PONE;
      if (pop)  rd_d    = rd_q + PONE;
      count_d = count_q + fire_w - pop_w;
      pend_d  = pend_q + fire_w - keep_w;
      if (imem_rsp_valid && draining) drop_d = drop_q - rsp_w;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alloc_q <= '0;
      fill_q  <= '0;
      rd_q    <= '0;
      count_q <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
    end else begin
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  FetchSlots #(.DEPTH(DEPTH)) u_slots (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .alloc_we_i   (fire),
    .alloc_idx_i  (alloc_q),
    .alloc_pc_i   (pc_in),
    .fill_we_i    (keep),
    .fill_idx_i   (fill_q),
    .fill_data_i  (imem_rsp_data),
    .pop_i        (pop),
    .rd_idx_i     (rd_q),
    .head_pc_o    (head_pc),
    .head_instr_o (head_instr),
    .head_filled_o(head_filled)
  );

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized bench for fetch_buffer with an in-order memory model and a
// queue-based reference of what decode should see.
module tb_fetch_buffer;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk, rst;
  logic        pc_valid, pc_ready, imem_req_valid, imem_req_ready;
  logic [31:0] pc_in, imem_req_addr, imem_rsp_data, instr, instr_pc;
  logic        imem_rsp_valid, flush, instr_valid, instr_ready;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc_in(pc_in), .pc_ready(pc_ready),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .flush(flush), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] data; int epoch; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  mreq_t memq[$];   // requests the memory still owes a response for
  ent_t  expq[$];   // fetches decode should still see, oldest first
  int    n_arr;     // responses received for the oldest expq entries

  int checks = 0, failures = 0;
  int cyc = 0, epoch = 0, last_due = 0, n_fire = 0, n_pop = 0;
  int g_lmin = 1, g_lmax = 1;
  logic g_pcv, g_qrdy, g_irdy, g_flush;
  logic [31:0] next_pc, last_pc;
  logic e_prdy, e_rvld, e_ivld, o_prdy, o_rvld, o_ivld;
  logic [31:0] e_ipc, e_instr, o_ipc, o_instr, o_addr;

  task automatic clear_model();
    memq.delete(); expq.delete();
    n_arr = 0; epoch = 0; last_due = cyc; n_fire = 0; n_pop = 0; last_pc = 32'hFFFF_FFFF;
  endtask

  task automatic apply_reset();
    rst = 1'b0; pc_valid = 0; pc_in = 0; imem_req_ready = 0; imem_rsp_valid = 0;
    imem_rsp_data = 0; flush = 0; instr_ready = 0;
    g_pcv = 0; g_qrdy = 1; g_irdy = 1; g_flush = 0; next_pc = 0;
    @(negedge clk); @(negedge clk);
    clear_model();
    rst = 1'b1;
  endtask

  // One cycle: drive inputs, compute expected outputs, sample DUT, advance model.
  task automatic step();
    int stale, lat, due;
    bit have;
    mreq_t r;
    logic [31:0] d;
    pc_valid = g_pcv; pc_in = next_pc; imem_req_ready = g_qrdy;
    instr_ready = g_irdy; flush = g_flush;
    have = 0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      have = 1; r = memq[0]; imem_rsp_valid = 1; imem_rsp_data = r.data;
    end else begin
      imem_rsp_valid = 0; imem_rsp_data = $urandom;
    end
    stale = 0;
    foreach (memq[i]) if (memq[i].epoch != epoch) stale++;
    e_prdy = g_qrdy && expq.size() < DEPTH && stale == 0 && !g_flush;
    e_rvld = g_pcv && expq.size() < DEPTH && stale == 0 && !g_flush;
    e_ivld = n_arr > 0 && !g_flush;
    e_ipc = 0; e_instr = NOP;
    if (expq.size() > 0 && e_ivld) begin e_ipc = expq[0].pc; e_instr = expq[0].data; end
    #1;
    o_prdy = pc_ready; o_rvld = imem_req_valid; o_ivld = instr_valid;
    o_ipc = instr_pc; o_instr = instr; o_addr = imem_req_addr;
    if (have) void'(memq.pop_front());
    if (g_flush) begin
      expq.delete(); n_arr = 0; epoch++;
    end else begin
      if (e_ivld && g_irdy) begin
        last_pc = expq[0].pc; void'(expq.pop_front()); n_arr--; n_pop++;
      end
      if (have && r.epoch == epoch) n_arr++;
      if (g_pcv && e_prdy) begin
        lat = $urandom_range(g_lmax, g_lmin);
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        last_due = due; d = $urandom;
        memq.push_back('{due: due, data: d, epoch: epoch});
        expq.push_back('{pc: next_pc, data: d});
        next_pc += 4; n_fire++;
      end
    end
    @(posedge clk); @(negedge clk); cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b0; pc_valid = 1; pc_in = 32'h40; imem_req_ready = 1; instr_ready = 1;
    flush = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    @(negedge clk); #1;
    checks++;
    if ({pc_ready, imem_req_valid, instr_valid} !== 3'b000) begin
      failures++; $display("FAIL reset_outputs got=%b exp=000", {pc_ready, imem_req_valid, instr_valid});
    end
    checks++;
    if (instr !== NOP) begin
      failures++; $display("FAIL reset_nop got=%h exp=%h", instr, NOP);
    end
  endtask

  task automatic test_stream();
    apply_reset();
    g_lmin = 1; g_lmax = 1; g_pcv = 1; g_qrdy = 1; g_irdy = 1; next_pc = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      checks++;
      if ({o_prdy, o_rvld, o_ivld} !== {e_prdy, e_rvld, e_ivld} || o_addr !== pc_in) begin
        failures++; $display("FAIL stream_hs cyc=%0d got=%b/%h exp=%b/%h", cyc, {o_prdy, o_rvld, o_ivld}, o_addr, {e_prdy, e_rvld, e_ivld}, pc_in);
      end
      if (e_ivld) begin
        checks++;
        if ({o_ipc, o_instr} !== {e_ipc, e_instr}) begin
          failures++; $display("FAIL stream_data cyc=%0d got=%h/%h exp=%h/%h", cyc, o_ipc, o_instr, e_ipc, e_instr);
        end
      end
    end
    checks++;
    if (n_pop != 12) begin failures++; $display("FAIL stream_rate got=%0d exp=12", n_pop); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    g_lmin = 1; g_lmax = 1; g_pcv = 1; g_qrdy = 1; g_irdy = 0; next_pc = 0;
    for (int i = 0; i < 18; i++) begin
      if (i == 8) begin
        checks++;
        if (n_fire != 4) begin failures++; $display("FAIL bp_fired got=%0d exp=4", n_fire); end
        g_irdy = 1;
      end
      step();
      checks++;
      if ({o_prdy, o_rvld, o_ivld} !== {e_prdy, e_rvld, e_ivld}) begin
        failures++; $display("FAIL bp_hs cyc=%0d got=%b exp=%b", cyc, {o_prdy, o_rvld, o_ivld}, {e_prdy, e_rvld, e_ivld});
      end
      if (e_ivld) begin
        checks++;
        if ({o_ipc, o_instr} !== {e_ipc, e_instr}) begin
          failures++; $display("FAIL bp_data cyc=%0d got=%h/%h exp=%h/%h", cyc, o_ipc, o_instr, e_ipc, e_instr);
        end
      end
    end
    checks++;
    if (n_pop < 8) begin failures++; $display("FAIL bp_resume got=%0d exp>=8", n_pop); end
  endtask

  // Issue 0x100..0x108, flush, then fetch tgt; lat controls whether a response meets the flush.
  task automatic run_flush(input int lat, input logic [31:0] tgt, input string nm);
    apply_reset();
    g_lmin = lat; g_lmax = lat; g_pcv = 1; g_qrdy = 1; g_irdy = 1; next_pc = 32'h100;
    for (int i = 0; i < 20; i++) begin
      g_pcv = (i < 3) || (i >= 4);
      g_flush = (i == 3);
      if (i == 4) next_pc = tgt;
      if (i > 4 && n_fire > 3) g_pcv = 0;
      step();
      checks++;
      if ({o_prdy, o_rvld, o_ivld} !== {e_prdy, e_rvld, e_ivld}) begin
        failures++; $display("FAIL %s_hs cyc=%0d got=%b exp=%b", nm, cyc, {o_prdy, o_rvld, o_ivld}, {e_prdy, e_rvld, e_ivld});
      end
      if (e_ivld) begin
        checks++;
        if ({o_ipc, o_instr} !== {e_ipc, e_instr}) begin
          failures++; $display("FAIL %s_data cyc=%0d got=%h/%h exp=%h/%h", nm, cyc, o_ipc, o_instr, e_ipc, e_instr);
        end
      end
    end
    g_flush = 0;
    checks++;
    if (n_pop != 1 || last_pc !== tgt) begin
      failures++; $display("FAIL %s_target pops=%0d last=%h exp=1/%h", nm, n_pop, last_pc, tgt);
    end
  endtask

  task automatic test_flush_inflight(); run_flush(4, 32'h200, "flush_inflight"); endtask
  task automatic test_flush_rsp();      run_flush(3, 32'h300, "flush_rsp");      endtask

  task automatic test_wrap();
    apply_reset();
    g_lmin = 1; g_lmax = 3; next_pc = 0;
    for (int i = 0; i < 400 && n_pop < 20; i++) begin
      g_pcv = (n_fire < 20); g_qrdy = $urandom_range(1, 0); g_irdy = $urandom_range(1, 0);
      step();
      checks++;
      if ({o_prdy, o_rvld, o_ivld} !== {e_prdy, e_rvld, e_ivld}) begin
        failures++; $display("FAIL wrap_hs cyc=%0d got=%b exp=%b", cyc, {o_prdy, o_rvld, o_ivld}, {e_prdy, e_rvld, e_ivld});
      end
      if (e_ivld) begin
        checks++;
        if ({o_ipc, o_instr} !== {e_ipc, e_instr}) begin
          failures++; $display("FAIL wrap_data cyc=%0d got=%h/%h exp=%h/%h", cyc, o_ipc, o_instr, e_ipc, e_instr);
        end
      end
    end
    checks++;
    if (n_pop != 20 || last_pc !== 32'h4C) begin
      failures++; $display("FAIL wrap_count pops=%0d last=%h exp=20/0000004c", n_pop, last_pc);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    g_lmin = 1; g_lmax = 1; g_qrdy = 1; g_irdy = 0; next_pc = 32'h80;
    for (int i = 0; i < 6; i++) begin
      g_pcv = (n_fire < 3);
      step();
    end
    checks++;
    if (o_ivld !== 1'b1 || e_ivld !== 1'b1) begin
      failures++; $display("FAIL arst_buffered got=%b exp=1", o_ivld);
    end
    pc_valid = 1; imem_req_ready = 1;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({instr_valid, imem_req_valid, pc_ready} !== 3'b000) begin
      failures++; $display("FAIL arst_immediate got=%b exp=000", {instr_valid, imem_req_valid, pc_ready});
    end
    imem_rsp_valid = 0;
    @(negedge clk);
    clear_model();
    rst = 1'b1; next_pc = 0; g_irdy = 1;
    for (int i = 0; i < 6; i++) begin
      g_pcv = (n_fire < 1);
      step();
      checks++;
      if ({o_prdy, o_rvld, o_ivld} !== {e_prdy, e_rvld, e_ivld}) begin
        failures++; $display("FAIL arst_hs cyc=%0d got=%b exp=%b", cyc, {o_prdy, o_rvld, o_ivld}, {e_prdy, e_rvld, e_ivld});
      end
      if (e_ivld) begin
        checks++;
        if ({o_ipc, o_instr} !== {e_ipc, e_instr}) begin
          failures++; $display("FAIL arst_data cyc=%0d got=%h/%h exp=%h/%h", cyc, o_ipc, o_instr, e_ipc, e_instr);
        end
      end
    end
    checks++;
    if (n_pop != 1 || last_pc !== 32'h0) begin
      failures++; $display("FAIL arst_refetch pops=%0d last=%h exp=1/00000000", n_pop, last_pc);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_inflight();
    test_flush_rsp();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
